// File: rtl/match_reporter.sv
// Accept-table lookup on the per-byte state stream; buffers match records in a FIFO.
// Optional MATCH_REPORTER_CNT_EN adds a saturating MATCH_CNT of all stage-1 hits.
module match_reporter #(
  parameter int STATE_W    = 8,
  parameter int ID_W       = 4,
  parameter int POS_W      = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  input  logic               EN,
  input  logic [STATE_W-1:0] NOW_STATE,
  input  logic               CFG_WE,
  input  logic [STATE_W-1:0] CFG_ADDR,
  input  logic               CFG_ACC,
  input  logic [ID_W-1:0]    CFG_ID,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [ID_W-1:0]    OUT_ID,
  output logic [POS_W-1:0]   OUT_POS,
  output logic [LW-1:0]      FIFO_LEVEL,
  output logic               OVERFLOW,
  output logic [7:0]         DROP_CNT
`ifdef MATCH_REPORTER_CNT_EN
  ,
  output logic [31:0]        MATCH_CNT
`endif
);

  localparam int NS = 2 ** STATE_W;
  localparam int RW = ID_W + POS_W;

  logic [NS-1:0]    acc_q;
  logic [ID_W-1:0]  id_q [NS];
  logic [POS_W-1:0] pos_q;
  logic             hit_q;
  logic [ID_W-1:0]  hit_id_q;
  logic [POS_W-1:0] hit_pos_q;
  logic [RW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [LW-1:0]    lvl_q;
  logic             ovf_q;
  logic [7:0]       drop_q;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [RW-1:0]    head;

  // Handshake decode: a full FIFO still accepts a push when it pops too
  always_comb begin
    full = (lvl_q == LW'(FIFO_DEPTH));
    pop  = (lvl_q != '0) && OUT_READY;
    push = hit_q && (!full || pop);
    drop = hit_q && full && !pop;
    head = mem_q[rd_q];
  end

  assign OUT_VALID  = (lvl_q != '0);
  assign OUT_ID     = OUT_VALID ? head[RW-1:POS_W] : '0;
  assign OUT_POS    = OUT_VALID ? head[POS_W-1:0] : '0;
  assign FIFO_LEVEL = lvl_q;
  assign OVERFLOW   = ovf_q;
  assign DROP_CNT   = drop_q;

  // Accept table; survives CLR, writes land on their own edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q <= '0;
      for (int i = 0; i < NS; i++) id_q[i] <= '0;
    end else if (CFG_WE) begin
      acc_q[CFG_ADDR] <= CFG_ACC;
      id_q[CFG_ADDR]  <= CFG_ID;
    end
  end

  // Byte position and stage-1 lookup register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pos_q     <= '0;
      hit_q     <= 1'b0;
      hit_id_q  <= '0;
      hit_pos_q <= '0;
    end else if (CLR) begin
      pos_q     <= '0;
      hit_q     <= 1'b0;
      hit_id_q  <= '0;
      hit_pos_q <= '0;
    end else begin
      hit_q <= EN && acc_q[NOW_STATE];
      if (EN) begin
        hit_id_q  <= id_q[NOW_STATE];
        hit_pos_q <= pos_q;
        pos_q     <= pos_q + 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care outside the valid window
  always_ff @(posedge CLK) begin
    if (push && !CLR) mem_q[wr_q] <= {hit_id_q, hit_pos_q};
  end

  // FIFO pointers, level and drop bookkeeping
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_q   <= '0;
      wr_q   <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (CLR) begin
      rd_q   <= '0;
      wr_q   <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

`ifdef MATCH_REPORTER_CNT_EN
  logic [31:0] mcnt_q;

  assign MATCH_CNT = mcnt_q;

  // Saturating count of every stage-1 hit, dropped or not
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mcnt_q <= '0;
    end else if (CLR) begin
      mcnt_q <= '0;
    end else if (hit_q && (mcnt_q != '1)) begin
      mcnt_q <= mcnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_match_reporter.sv
// Directed bench for match_reporter: queue-based reference model
// checked every cycle, plus literal expectations from the test plan.
module tb_match_reporter;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CLR = 1'b0;
  logic        EN = 1'b0;
  logic [7:0]  NOW_STATE = '0;
  logic        CFG_WE = 1'b0;
  logic [7:0]  CFG_ADDR = '0;
  logic        CFG_ACC = 1'b0;
  logic [3:0]  CFG_ID = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [3:0]  OUT_ID;
  logic [15:0] OUT_POS;
  logic [3:0]  FIFO_LEVEL;
  logic        OVERFLOW;
  logic [7:0]  DROP_CNT;
`ifdef MATCH_REPORTER_CNT_EN
  logic [31:0] MATCH_CNT;
`endif

  match_reporter dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN),
    .NOW_STATE(NOW_STATE), .CFG_WE(CFG_WE),
    .CFG_ADDR(CFG_ADDR), .CFG_ACC(CFG_ACC),
    .CFG_ID(CFG_ID), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_ID(OUT_ID),
    .OUT_POS(OUT_POS), .FIFO_LEVEL(FIFO_LEVEL),
    .OVERFLOW(OVERFLOW), .DROP_CNT(DROP_CNT)
`ifdef MATCH_REPORTER_CNT_EN
    , .MATCH_CNT(MATCH_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // reference model: table, position, one pending hit, record queue
  bit          m_acc [256];
  bit [3:0]    m_id  [256];
  bit [15:0]   m_pos;
  bit          m_pend;
  bit [19:0]   m_rec;
  bit [19:0]   m_q [$];
  bit          m_ovf;
  int          m_drop;
  longint      m_cnt;
  bit          nh;
  bit [19:0]   nr;

  always @(negedge RST) begin
    foreach (m_acc[i]) begin
      m_acc[i] = 1'b0;
      m_id[i]  = '0;
    end
    m_pos = '0; m_pend = 1'b0; m_q.delete();
    m_ovf = 1'b0; m_drop = 0; m_cnt = 0;
  end

  always @(posedge CLK) begin
    if (RST) begin
      if (CLR) begin
        m_pos = '0; m_pend = 1'b0; m_q.delete();
        m_ovf = 1'b0; m_drop = 0; m_cnt = 0;
      end else begin
        nh = EN && m_acc[NOW_STATE];
        nr = {m_id[NOW_STATE], m_pos};
        if (m_q.size() > 0 && OUT_READY) void'(m_q.pop_front());
        if (m_pend) begin
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          if (m_q.size() < DEPTH) m_q.push_back(m_rec);
          else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
          end
        end
        m_pend = nh;
        m_rec  = nr;
        if (EN) m_pos = m_pos + 16'd1;
      end
      if (CFG_WE) begin
        m_acc[CFG_ADDR] = CFG_ACC;
        m_id[CFG_ADDR]  = CFG_ID;
      end
    end
  end

  // per-cycle compare and capture of records the host takes
  logic [19:0] got_q [$];
  logic        mv;
  logic [19:0] mh;

  always @(negedge CLK) begin
    if (RST) begin
      mv = (m_q.size() != 0);
      mh = mv ? m_q[0] : 20'd0;
      chk("cycle",
          {OUT_VALID, (OUT_VALID ? {OUT_ID, OUT_POS} : 20'd0),
           FIFO_LEVEL, OVERFLOW, DROP_CNT},
          {mv, mh, 4'(m_q.size()), m_ovf, 8'(m_drop)});
`ifdef MATCH_REPORTER_CNT_EN
      chk("match_cnt", MATCH_CNT, m_cnt);
`endif
      if (!CLR && OUT_VALID && OUT_READY)
        got_q.push_back({OUT_ID, OUT_POS});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input logic [7:0] a, input logic acc,
                     input logic [3:0] id);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_ACC = acc; CFG_ID = id;
    tick();
    CFG_WE = 1'b0;
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  logic [7:0] seq1 [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd3};

  initial begin
    // reset state
    tick(); tick();
    chk("rst_valid", OUT_VALID, 1'b0);
    chk("rst_level", FIFO_LEVEL, 4'd0);
    chk("rst_ovf", OVERFLOW, 1'b0);
    chk("rst_drop", DROP_CNT, 8'd0);
    chk("rst_id", OUT_ID, 4'd0);
    chk("rst_pos", OUT_POS, 16'd0);
    RST = 1'b1;
    tick();

    // two records from a short stream, latency of 2 edges
    cfg(8'd3, 1'b1, 4'd5);
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      EN = 1'b1; NOW_STATE = seq1[i];
      tick();
      if (i == 3) chk("lat_edge1", OUT_VALID, 1'b0);
      if (i == 4) chk("lat_edge2", {OUT_VALID, OUT_ID, OUT_POS},
                      {1'b1, 4'd5, 16'd3});
    end
    EN = 1'b0;
    tick(); tick();
    chk("s1_count", got_q.size(), 2);
    chk("s1_rec0", got_q[0], {4'd5, 16'd3});
    chk("s1_rec1", got_q[1], {4'd5, 16'd5});

    // fill to overflow with ready low
    clr_pulse();
    cfg(8'd7, 1'b1, 4'd2);
    OUT_READY = 1'b0;
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      EN = 1'b1; NOW_STATE = 8'd7;
      tick();
    end
    EN = 1'b0;
    tick();
    chk("full_level", FIFO_LEVEL, 4'd8);
    chk("full_ovf", OVERFLOW, 1'b1);
    chk("full_drop", DROP_CNT, 8'd2);

    // full FIFO, pop coincides with push: no drop
    EN = 1'b1; NOW_STATE = 8'd7;
    tick();
    EN = 1'b0; OUT_READY = 1'b1;
    tick();
    chk("pp_level", FIFO_LEVEL, 4'd8);
    chk("pp_drop", DROP_CNT, 8'd2);
    repeat (8) tick();
    chk("drain_count", got_q.size(), 9);
    for (int i = 0; i < 8; i++)
      chk("drain_pos", got_q[i], {4'd2, 16'(i)});
    chk("drain_last", got_q[8], {4'd2, 16'd10});
    chk("drain_level", FIFO_LEVEL, 4'd0);

    // same-edge config write is not seen by the lookup
    clr_pulse();
    got_q.delete();
    CFG_WE = 1'b1; CFG_ADDR = 8'd4; CFG_ACC = 1'b1; CFG_ID = 4'd9;
    EN = 1'b1; NOW_STATE = 8'd4;
    tick();
    CFG_WE = 1'b0; EN = 1'b0;
    tick(); tick();
    chk("cfg_same_edge", got_q.size(), 0);
    EN = 1'b1; NOW_STATE = 8'd4;
    tick();
    EN = 1'b0;
    tick(); tick();
    chk("cfg_next_cnt", got_q.size(), 1);
    chk("cfg_next_rec", got_q[0], {4'd9, 16'd1});

    // position wrap
    clr_pulse();
    got_q.delete();
    EN = 1'b1; NOW_STATE = 8'd0;
    repeat (65535) tick();
    NOW_STATE = 8'd3;
    tick(); tick();
    EN = 1'b0;
    tick(); tick(); tick();
    chk("wrap_cnt", got_q.size(), 2);
    chk("wrap_rec0", got_q[0], {4'd5, 16'd65535});
    chk("wrap_rec1", got_q[1], {4'd5, 16'd0});

    // async reset with 3 queued and a hit in stage 1
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      EN = 1'b1; NOW_STATE = 8'd3;
      tick();
    end
    EN = 1'b0;
    chk("pre_rst_level", FIFO_LEVEL, 4'd3);
    #3 RST = 1'b0;
    #2;
    chk("arst", {OUT_VALID, FIFO_LEVEL, OVERFLOW},
        {1'b0, 4'd0, 1'b0});
    tick();
    RST = 1'b1;
    tick(); tick();
    chk("arst_kill", FIFO_LEVEL, 4'd0);

    // CLR with 3 queued; table survives
    cfg(8'd3, 1'b1, 4'd5);
    for (int i = 0; i < 4; i++) begin
      EN = 1'b1; NOW_STATE = 8'd3;
      tick();
    end
    EN = 1'b0;
    chk("pre_clr_level", FIFO_LEVEL, 4'd3);
    clr_pulse();
    chk("clr", {OUT_VALID, FIFO_LEVEL, OVERFLOW},
        {1'b0, 4'd0, 1'b0});
    tick(); tick();
    chk("clr_kill", FIFO_LEVEL, 4'd0);
    OUT_READY = 1'b1;
    got_q.delete();
    EN = 1'b1; NOW_STATE = 8'd3;
    tick();
    EN = 1'b0;
    tick(); tick();
    chk("clr_tbl_cnt", got_q.size(), 1);
    chk("clr_tbl_rec", got_q[0], {4'd5, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
